// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one alu, one transaction in flight.
// Ports: i_clk/i_rst (async, active-high); req0/req1 valid/ready with op1, op2, control;
// response valid/ready with id, result, zero flag and illegal-op flag.

module alu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic [CTRL_W-1:0] control,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    output logic [WIDTH-1:0]  result,
    output logic              zf
);
    localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] C_SOLT = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] C_NOR  = CTRL_W'(4'b1100);

    always_comb begin
        result = '0;
        case (control)
            C_AND:   result = op1 & op2;
            C_OR:    result = op1 | op2;
            C_ADD:   result = op1 + op2;
            C_SUB:   result = op1 - op2;
            C_SOLT:  result = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            C_NOR:   result = ~(op1 | op2);
            default: result = '0;
        endcase
        zf = result == '0;
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [WIDTH-1:0]  i_req0_op1,
    input  logic [WIDTH-1:0]  i_req0_op2,
    input  logic [CTRL_W-1:0] i_req0_control,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [WIDTH-1:0]  i_req1_op1,
    input  logic [WIDTH-1:0]  i_req1_op2,
    input  logic [CTRL_W-1:0] i_req1_control,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [WIDTH-1:0]  o_rsp_result,
    output logic              o_rsp_zf,
    output logic              o_rsp_illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nx;
    logic              last_grant, gnt, accept, legal, alu_zf;
    logic [WIDTH-1:0]  op1_q, op2_q, alu_res;
    logic [CTRL_W-1:0] ctrl_q;

    alu #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_alu (
        .control(ctrl_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .result (alu_res),
        .zf     (alu_zf)
    );

    assign legal = ctrl_q inside {CTRL_W'(4'b0000), CTRL_W'(4'b0001), CTRL_W'(4'b0010),
                                  CTRL_W'(4'b0110), CTRL_W'(4'b0111), CTRL_W'(4'b1100)};

    // ready is masked by reset so that every output reads 0 while reset is held
    always_comb begin
        gnt          = (i_req0_valid && i_req1_valid) ? ~last_grant : i_req1_valid;
        accept       = state == IDLE && (i_req0_valid || i_req1_valid) && !i_rst;
        o_req0_ready = accept && !gnt;
        o_req1_ready = accept && gnt;
        o_rsp_valid  = state == RESP;
        state_nx     = state;
        case (state)
            IDLE:    state_nx = accept ? EXEC : IDLE;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = i_rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant    <= 1'b1;
            op1_q         <= '0;
            op2_q         <= '0;
            ctrl_q        <= '0;
            o_rsp_id      <= 1'b0;
            o_rsp_result  <= '0;
            o_rsp_zf      <= 1'b0;
            o_rsp_illegal <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= gnt;
                o_rsp_id   <= gnt;
                op1_q      <= gnt ? i_req1_op1 : i_req0_op1;
                op2_q      <= gnt ? i_req1_op2 : i_req0_op2;
                ctrl_q     <= gnt ? i_req1_control : i_req0_control;
            end
            // illegal codes still go through the alu but report a forced zero result
            if (state == EXEC) begin
                o_rsp_result  <= legal ? alu_res : '0;
                o_rsp_zf      <= legal ? alu_zf : 1'b1;
                o_rsp_illegal <= !legal;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, corner sequences and randomized model checking for alu_arbiter.
module tb_alu_arbiter;
    logic        clk = 0, rst = 1;
    logic        v0 = 0, v1 = 0, r0, r1;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [3:0]  c0 = 0, c1 = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_id, zf, ill;
    logic [31:0] res;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op1(a0), .i_req0_op2(b0), .i_req0_control(c0),
        .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op1(a1), .i_req1_op2(b1), .i_req1_control(c1),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_result(res), .o_rsp_zf(zf), .o_rsp_illegal(ill)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // {illegal, zf, result}
    function automatic logic [33:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        il;
        il = 0;
        case (c)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd6:    r = a - b;
            4'd7:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   r = ~(a | b);
            default: begin r = 0; il = 1; end
        endcase
        return {il, r == 0, r};
    endfunction

    task automatic drive(input bit id, input bit v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (id) begin v1 = v; c1 = c; a1 = a; b1 = b; end
        else    begin v0 = v; c0 = c; a0 = a; b0 = b; end
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    typedef struct {
        bit          id;
        logic [3:0]  c;
        logic [31:0] a, b, res;
        logic        zf, ill;
    } vec_t;

    typedef struct {
        bit          id;
        logic [33:0] exp;
    } txn_t;

    vec_t        vt[12];
    int          gids[$], rids[$];
    logic [31:0] rres[$];
    txn_t        exp_q[$];
    logic [31:0] snap;
    logic [3:0]  codes[8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};

    initial begin
        vt[0]  = '{0, 4'd2,  32'd512,        32'd300,        32'd812,        0, 0};
        vt[1]  = '{1, 4'd3,  32'd7,          32'd9,          32'd0,          1, 1};
        vt[2]  = '{1, 4'd12, 32'h0000_0300,  32'h0000_F03F,  32'hFFFF_0CC0,  0, 0};
        vt[3]  = '{0, 4'd6,  32'd1000,       32'd1000,       32'd0,          1, 0};
        vt[4]  = '{0, 4'd7,  32'd3,          32'd63,         32'd1,          0, 0};
        vt[5]  = '{1, 4'd7,  32'hFFFF_FFFF,  32'd1,          32'd1,          0, 0};
        vt[6]  = '{0, 4'd7,  32'd5,          32'hFFFF_FFFE,  32'd0,          1, 0};
        vt[7]  = '{1, 4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0,          1, 0};
        vt[8]  = '{0, 4'd6,  32'd0,          32'd1,          32'hFFFF_FFFF,  0, 0};
        vt[9]  = '{1, 4'd1,  32'hF0F0_0000,  32'h0000_000F,  32'hF0F0_000F,  0, 0};
        vt[10] = '{0, 4'd0,  32'h1234_5678,  32'h0F0F_0F0F,  32'h0204_0608,  0, 0};
        vt[11] = '{1, 4'd15, 32'd1,          32'd2,          32'd0,          1, 1};

        @(negedge clk);
        #1;
        chk("rst_outputs", {r0, r1, rsp_valid, rsp_id, ill, zf, res}, 0);
        @(negedge clk);
        rst = 0;

        // directed table with exact latency
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].id, 1, vt[i].c, vt[i].a, vt[i].b);
            #1;
            chk("vec_rdy_own", vt[i].id ? r1 : r0, 1);
            chk("vec_rdy_other", vt[i].id ? r0 : r1, 0);
            @(posedge clk);
            @(negedge clk);
            drive(vt[i].id, 0, 0, 0, 0);
            #1;
            chk("vec_exec_novalid", rsp_valid, 0);
            @(negedge clk);
            #1;
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_id", rsp_id, vt[i].id);
            chk("vec_result", res, vt[i].res);
            chk("vec_zf", zf, vt[i].zf);
            chk("vec_illegal", ill, vt[i].ill);
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            #1;
            chk("vec_rsp_done", rsp_valid, 0);
        end

        // contention after reset: both held valid for four transactions
        do_reset();
        drive(0, 1, 4'd6, 32'd3211, 32'd3011);
        drive(1, 1, 4'd0, 32'h0000_FF00, 32'h0000_B10F);
        rsp_ready = 1;
        for (int k = 0; k < 16 && rids.size() < 4; k++) begin
            #1;
            chk("cont_both_ready", r0 & r1, 0);
            if (r0) gids.push_back(0);
            if (r1) gids.push_back(1);
            if (rsp_valid) begin
                rids.push_back(rsp_id);
                rres.push_back(res);
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rsp_ready = 0;
        chk("cont_rsp_count", rids.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("cont_grant_order", k < gids.size() ? gids[k] : 32'hDEAD, k % 2);
            chk("cont_rsp_id", k < rids.size() ? rids[k] : 32'hDEAD, k % 2);
            chk("cont_rsp_result", k < rres.size() ? rres[k] : 32'hDEAD, (k % 2) ? 32'h0000_B100 : 32'd200);
        end
        @(negedge clk);

        // backpressure with a competing request held through RESP and the handshake cycle
        drive(0, 1, 4'd6, 32'd1000, 32'd1000);
        #1;
        chk("bp_rdy0", r0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 4'd1, 32'd5, 32'd10);
        #1;
        chk("bp_exec_rdy1", r1, 0);
        @(negedge clk);
        #1;
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_id", rsp_id, 0);
        chk("bp_result", res, 0);
        chk("bp_zf", zf, 1);
        snap = {rsp_id, zf, ill, res[28:0]};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_fields", {rsp_id, zf, ill, res[28:0]}, snap);
            chk("bp_hold_result", res, 0);
            chk("bp_no_ready", r0 | r1, 0);
        end
        rsp_ready = 1;
        #1;
        chk("bp_hs_no_accept", r1, 0);
        @(negedge clk);
        rsp_ready = 0;
        #1;
        chk("bp_after_valid", rsp_valid, 0);
        chk("bp_next_rdy1", r1, 1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("bp2_rsp_id", rsp_id, 1);
        chk("bp2_result", res, 15);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;

        // reset pulse in EXEC after a req0 grant
        drive(0, 1, 4'd2, 32'd1, 32'd2);
        #1;
        chk("rx_rdy0", r0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 4'd1, 32'd1, 32'd2);
        rst = 1;
        #1;
        chk("rx_outputs_zero", {r0, r1, rsp_valid, rsp_id, ill, zf, res}, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rx_no_response", rsp_valid, 0);
        end
        drive(0, 1, 4'd7, 32'd3, 32'd63);
        drive(1, 1, 4'd1, 32'd1, 32'd2);
        #1;
        chk("rx_first_rdy0", r0, 1);
        chk("rx_first_rdy1", r1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rx_rsp_id", rsp_id, 0);
        chk("rx_rsp_result", res, 1);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;

        // randomized traffic against a transaction-level model
        do_reset();
        begin
            bit          mv[2], mlast, busy, s0, s1, sv, sr;
            logic [3:0]  mc[2];
            logic [31:0] ma[2], mb[2];
            int          age;
            mv = '{0, 0};
            mlast = 1;
            age = 0;
            for (int cyc = 0; cyc < 610; cyc++) begin
                for (int r = 0; r < 2; r++) begin
                    if (cyc >= 600) mv[r] = 0;
                    else if (!mv[r] && $urandom_range(0, 1) == 1) begin
                        mv[r] = 1;
                        mc[r] = codes[$urandom_range(0, 7)];
                        ma[r] = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) : $urandom;
                        mb[r] = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) : $urandom;
                    end else if (mv[r] && $urandom_range(0, 15) == 0) mv[r] = 0;
                    drive(r[0], mv[r], mc[r], ma[r], mb[r]);
                end
                rsp_ready = cyc >= 600 || $urandom_range(0, 2) != 0;
                #1;
                busy = exp_q.size() != 0;
                chk("rnd_rdy0", r0, !busy && mv[0] && (!mv[1] || mlast));
                chk("rnd_rdy1", r1, !busy && mv[1] && (!mv[0] || !mlast));
                chk("rnd_rsp_valid", rsp_valid, busy && age >= 1);
                if (rsp_valid && busy) begin
                    chk("rnd_rsp_id", rsp_id, exp_q[0].id);
                    chk("rnd_result", res, exp_q[0].exp[31:0]);
                    chk("rnd_zf", zf, exp_q[0].exp[32]);
                    chk("rnd_illegal", ill, exp_q[0].exp[33]);
                end
                s0 = r0; s1 = r1; sv = rsp_valid; sr = rsp_ready;
                @(posedge clk);
                if (sv && sr && busy) void'(exp_q.pop_front());
                if (s0 || s1) begin
                    exp_q.push_back('{s1, s1 ? ref_alu(mc[1], ma[1], mb[1]) : ref_alu(mc[0], ma[0], mb[0])});
                    mlast = s1;
                    mv[s1] = 0;
                    age = 0;
                end else age++;
                @(negedge clk);
            end
            chk("rnd_drained", exp_q.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-port round-robin arbiter and sequencer that shares a single instance of the core `alu` between two requesters. Example requesters are the main execute stage and an auxiliary address/branch unit. The block accepts an operation through a valid/ready handshake and latches the operands. It drives the ALU for one cycle, registers the result, and returns it with a requester ID through a valid/ready response handshake. One transaction is in flight at a time.

Parameters:
WIDTH, 32, operand/result width passed to the ALU
CTRL_W, 4, width of the ALU control code

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous reset, active-high
i_req0_valid  input  1  requester 0 has an operation
o_req0_ready  output  1  requester 0 operation accepted this cycle
i_req0_op1  input  WIDTH  requester 0 operand 1
i_req0_op2  input  WIDTH  requester 0 operand 2
i_req0_control  input  CTRL_W  requester 0 ALU control code
i_req1_valid, o_req1_ready, i_req1_op1, i_req1_op2, i_req1_control  same widths and meaning, requester 1
o_rsp_valid  output  1  response available
i_rsp_ready  input  1  consumer accepts response
o_rsp_id  output  1  requester that issued the response (0/1)
o_rsp_result  output  WIDTH  ALU result
o_rsp_zf  output  1  ALU zero flag
o_rsp_illegal  output  1  control code was not a legal ALU op

Behaviour:
- Legal control codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SOLT=0111, NOR=1100. Any other code is still issued to the ALU; the block sets o_rsp_illegal=1 and forces o_rsp_result=0 and o_rsp_zf=1.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any valid is high, grant one requester: combinational o_reqN_ready=1 for the granted one only.
  - Latch op1, op2, control and id; go to EXEC.
  - Ready is never asserted outside IDLE, and never to both requesters in one cycle.
- Arbitration:
  - Pointer last_grant, reset value 1, so requester 0 wins the first contention.
  - If both are valid, grant the requester not equal to last_grant.
  - If only one is valid, grant it.
  - last_grant updates at acceptance.
- EXEC: ALU is driven from the latched registers. Result, zf and illegal are registered on the rising edge; go to RESP.
- RESP:
  - o_rsp_valid=1; o_rsp_* stay stable until the handshake.
  - On i_rsp_ready=1, go to IDLE; o_rsp_valid drops next cycle.
  - No new request is accepted in the handshake cycle.
- Latency: request accepted at edge T, o_rsp_valid high after edge T+1. Minimum issue interval is 3 cycles.
- Requester rule: valid and payload must be held stable until ready. Deassertion before ready is allowed, and nothing is latched.
- Arithmetic is as defined by the ALU: wrap-around on ADD/SUB with no overflow flag; SOLT is a signed compare giving 1 or 0.
- Reset (any time, including mid-EXEC/RESP):
  - Asynchronously returns to IDLE and drops any in-flight transaction.
  - All outputs go to 0: o_req*_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_zf, o_rsp_illegal.
  - last_grant returns to 1.
- Responses are never duplicated or lost outside reset. The response ID always equals the ID of the accepted request.

Test Plan:
- Req0 ADD 512+300, i_rsp_ready=1 -> o_req0_ready for 1 cycle; two edges later o_rsp_valid=1, id=0, result=812, zf=0, illegal=0.
- Both valid simultaneously after reset: req0 SUB 3211-3011, req1 AND 0xFF00&0xB10F. Response order: (id=0, result=200), then (id=1, result=0xB100); req1 is held until its ready.
- Back-to-back contention, both continuously valid for 4 transactions -> grants alternate 0,1,0,1; ready is never high on both.
- Backpressure: i_rsp_ready=0 for 5 cycles during RESP -> o_rsp_valid and o_rsp_* stable, no ready issued. Req0 SUB 1000-1000 -> result=0, zf=1.
- Illegal op: req1 control=0011, op1=7, op2=9 -> id=1, illegal=1, result=0, zf=1. The next legal req1 NOR 0x0300,0xF03F returns 0xFFFF0CC0 with illegal=0.
- Reset pulse while in EXEC -> all outputs 0 immediately, no response emitted. The next request (req0 SOLT 3,63) is granted first and returns result=1.
